// File: rtl/i2s_rx_if.sv
// i2s_rx_if -- stereo sample-pair stream from the I2S receiver to its consumer.
//   m_left  : left sample of the completed pair
//   m_right : right sample of the completed pair
//   m_valid : a pair is available
//   m_ready : the consumer accepts the pair
// modport master : producer side (the receiver)
// modport slave  : consumer side
interface i2s_rx_if #(
  parameter int DW = 24
);
  logic [DW-1:0] m_left;
  logic [DW-1:0] m_right;
  logic          m_valid;
  logic          m_ready;

  modport master (output m_left, output m_right, output m_valid, input m_ready);
  modport slave  (input m_left, input m_right, input m_valid, output m_ready);
endinterface

// File: rtl/i2s_rx.sv
// i2s_rx -- I2S (Philips, one-bit delay) receiver, oversampled in the clk domain.
//   clk       : system clock, all logic runs here
//   rst       : synchronous active-high reset
//   sclk_in   : external bit clock (asynchronous)
//   lrclk_in  : external word select, 0 = left, 1 = right (asynchronous)
//   sdata_in  : serial data, MSB first (asynchronous)
//   m_if      : pair output stream (m_left, m_right, m_valid, m_ready)
//   overrun   : one-cycle pulse when a completed pair is dropped
//   frame_err : one-cycle pulse on a short channel (only with I2S_RX_FRAME_ERR_EN)
// Build option: define I2S_RX_FRAME_ERR_EN to turn a short channel into a frame
// error (pulse, discard, realign). Without it a short channel is left-justified
// and zero-filled and treated as complete.
//
// state    | meaning
// ALIGN    | waiting for a 1->0 word-select boundary (start of left)
// DELAY    | boundary seen; next rising edge carries the MSB
// SHIFT    | shifting in the current channel's bits
// HOLD     | channel complete; ignoring extra bits until the next boundary
module i2s_rx #(
  parameter int DW = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk_in,
  input  logic lrclk_in,
  input  logic sdata_in,
  i2s_rx_if.master m_if,
  output logic overrun
`ifdef I2S_RX_FRAME_ERR_EN
  ,output logic frame_err
`endif
);

  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] CNT_DW   = CW'(DW);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  typedef enum logic [1:0] {ST_ALIGN, ST_DELAY, ST_SHIFT, ST_HOLD} state_t;

  logic r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic r_lr_s1, r_lr_s2, r_lr_prev;
  logic r_sd_s1, r_sd_s2;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_right_tgt, w_right_nxt;

  logic          w_sclk_rise;
  logic          w_bound;
  logic          w_chan_done;
  logic [DW-1:0] w_chan_word;
  logic          w_pair_done;

  logic [DW-1:0] r_left_hold;
  logic          r_left_ok;
  logic [DW-1:0] r_m_left, r_m_right;
  logic          r_m_valid;
  logic          r_overrun;

`ifdef I2S_RX_FRAME_ERR_EN
  logic          w_frame_err;
  logic          r_frame_err;
  assign frame_err = r_frame_err;
`endif

  assign m_if.m_left  = r_m_left;
  assign m_if.m_right = r_m_right;
  assign m_if.m_valid = r_m_valid;
  assign overrun      = r_overrun;

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
  // Boundary: word select differs from its value at the previous rising edge.
  assign w_bound     = r_lr_s2 ^ r_lr_prev;
  assign w_pair_done = w_chan_done & r_right_tgt & r_left_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_lr_s1   <= 1'b0;
      r_lr_s2   <= 1'b0;
      r_lr_prev <= 1'b0;
      r_sd_s1   <= 1'b0;
      r_sd_s2   <= 1'b0;
    end else begin
      r_sclk_s1 <= sclk_in;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_lr_s1   <= lrclk_in;
      r_lr_s2   <= r_lr_s1;
      r_sd_s1   <= sdata_in;
      r_sd_s2   <= r_sd_s1;
      if (w_sclk_rise) r_lr_prev <= r_lr_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ALIGN;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_right_tgt <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_right_tgt <= w_right_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_right_nxt = r_right_tgt;
    w_chan_done = 1'b0;
    w_chan_word = '0;
`ifdef I2S_RX_FRAME_ERR_EN
    w_frame_err = 1'b0;
`endif
    if (w_sclk_rise) begin
      case (r_state)
        ST_ALIGN: begin
          // Only a right->left transition marks a trustworthy frame start.
          if (w_bound && !r_lr_s2) begin
            w_state_nxt = ST_DELAY;
            w_right_nxt = 1'b0;
          end
        end
        ST_DELAY: begin
          w_shift_nxt = {{(DW-1){1'b0}}, r_sd_s2};
          w_cnt_nxt   = CW'(1);
          w_state_nxt = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_bound) begin
`ifdef I2S_RX_FRAME_ERR_EN
            w_frame_err = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_ALIGN;
`else
            // Short channel: move captured bits to the top, zeros below.
            w_chan_done = 1'b1;
            w_chan_word = r_shift << (CNT_DW - r_cnt);
            w_cnt_nxt   = '0;
            w_right_nxt = r_lr_s2;
            w_state_nxt = ST_DELAY;
`endif
          end else begin
            w_shift_nxt = {r_shift[DW-2:0], r_sd_s2};
            w_cnt_nxt   = r_cnt + CW'(1);
            if (r_cnt == CNT_LAST) begin
              w_chan_done = 1'b1;
              w_chan_word = {r_shift[DW-2:0], r_sd_s2};
              w_state_nxt = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (w_bound) begin
            w_cnt_nxt   = '0;
            w_right_nxt = r_lr_s2;
            w_state_nxt = ST_DELAY;
          end
        end
        default: w_state_nxt = ST_ALIGN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_left_hold <= '0;
      r_left_ok   <= 1'b0;
      r_m_left    <= '0;
      r_m_right   <= '0;
      r_m_valid   <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef I2S_RX_FRAME_ERR_EN
      r_frame_err <= 1'b0;
`endif
    end else begin
      r_overrun <= 1'b0;
`ifdef I2S_RX_FRAME_ERR_EN
      r_frame_err <= w_frame_err;
      if (w_frame_err) r_left_ok <= 1'b0;
`endif
      if (w_chan_done && !r_right_tgt) begin
        r_left_hold <= w_chan_word;
        r_left_ok   <= 1'b1;
      end
      if (w_pair_done) begin
        r_left_ok <= 1'b0;
        // A transfer in this same cycle frees the slot for the new pair.
        if (!r_m_valid || m_if.m_ready) begin
          r_m_left  <= r_left_hold;
          r_m_right <= w_chan_word;
          r_m_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_m_valid && m_if.m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
module tb_i2s_rx;
  localparam int DW = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk_in = 1'b0;
  logic lrclk_in = 1'b1;
  logic sdata_in = 1'b0;
  logic overrun;
`ifdef I2S_RX_FRAME_ERR_EN
  logic frame_err;
`endif

  i2s_rx_if #(.DW(DW)) bus ();

  i2s_rx #(.DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk_in  (sclk_in),
    .lrclk_in (lrclk_in),
    .sdata_in (sdata_in),
    .m_if     (bus),
    .overrun  (overrun)
`ifdef I2S_RX_FRAME_ERR_EN
    ,.frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: records every accepted pair and counts pulses.
  logic [DW-1:0] obs_l[$];
  logic [DW-1:0] obs_r[$];
  int n_ovr = 0;
  int n_vcyc = 0;
  int n_ferr = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_valid) n_vcyc++;
      if (bus.m_valid && bus.m_ready) begin
        obs_l.push_back(bus.m_left);
        obs_r.push_back(bus.m_right);
      end
      if (overrun) n_ovr++;
`ifdef I2S_RX_FRAME_ERR_EN
      if (frame_err) n_ferr++;
`endif
    end
  end

  // Reference: pairs the receiver must deliver, in order.
  logic [DW-1:0] exp_l[$];
  logic [DW-1:0] exp_r[$];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sbit(input logic lr, input logic d);
    sclk_in  = 1'b0;
    lrclk_in = lr;
    sdata_in = d;
    tick($urandom_range(2, 4));
    sclk_in = 1'b1;
    tick($urandom_range(2, 4));
  endtask

  // One channel: slot 0 is the I2S delay slot, then nbits MSB first, then filler.
  task automatic send_chan(input logic lr, input logic [DW-1:0] w, input int nbits,
                           input int slots, input bit fill_ones);
    sbit(lr, 1'($urandom_range(0, 1)));
    for (int i = 0; i < nbits; i++) sbit(lr, w[DW-1-i]);
    for (int i = nbits + 1; i < slots; i++)
      sbit(lr, fill_ones ? 1'b1 : 1'($urandom_range(0, 1)));
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    send_chan(1'b0, l, DW, 32, 1'b0);
    send_chan(1'b1, r, DW, 32, 1'b0);
  endtask

  task automatic check_pairs(input string tag, input int base);
    check_val({tag, "_count"}, 64'(obs_l.size() - base), 64'(exp_l.size()));
    for (int i = 0; i < exp_l.size() && base + i < obs_l.size(); i++) begin
      check_val({tag, "_left"},  obs_l[base+i], exp_l[i]);
      check_val({tag, "_right"}, obs_r[base+i], exp_r[i]);
    end
    exp_l.delete();
    exp_r.delete();
  endtask

  initial begin
    int base, ovr0, vc0, fe0;
    logic [DW-1:0] l1, r1, l2, r2, mask;

    bus.m_ready = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(2);
    check_val("rst_valid",   bus.m_valid, 1'b0);
    check_val("rst_left",    bus.m_left,  '0);
    check_val("rst_right",   bus.m_right, '0);
    check_val("rst_overrun", overrun,     1'b0);

    // Prime word-select history at 1 so the first left channel is a 1->0 boundary.
    for (int i = 0; i < 4; i++) sbit(1'b1, 1'b0);

    // Known pattern plus random frames, consumer always ready.
    base = obs_l.size(); ovr0 = n_ovr; vc0 = n_vcyc;
    exp_l.push_back(24'hA5A5A5); exp_r.push_back(24'h5A5A5A);
    send_frame(24'hA5A5A5, 24'h5A5A5A);
    for (int f = 0; f < 3; f++) begin
      l1 = DW'($urandom); r1 = DW'($urandom);
      exp_l.push_back(l1); exp_r.push_back(r1);
      send_frame(l1, r1);
    end
    tick(10);
    check_val("stream_vcycles", 64'(n_vcyc - vc0), 64'd4);
    check_val("stream_overrun", 64'(n_ovr - ovr0), 64'd0);
    check_pairs("stream", base);

    // Extra ones after the left word are ignored.
    base = obs_l.size();
    r1 = DW'($urandom);
    send_chan(1'b0, 24'h123456, DW, DW + 9, 1'b1);
    send_chan(1'b1, r1, DW, 32, 1'b0);
    tick(10);
    exp_l.push_back(24'h123456); exp_r.push_back(r1);
    check_pairs("extra", base);

    // Backpressure across two frames: first pair held, second dropped.
    base = obs_l.size(); ovr0 = n_ovr;
    bus.m_ready = 1'b0;
    l1 = DW'($urandom); r1 = DW'($urandom);
    l2 = DW'($urandom); r2 = DW'($urandom);
    send_frame(l1, r1);
    send_frame(l2, r2);
    tick(5);
    check_val("hold_valid", bus.m_valid, 1'b1);
    check_val("hold_left",  bus.m_left,  l1);
    check_val("hold_right", bus.m_right, r1);
    check_val("hold_overrun", 64'(n_ovr - ovr0), 64'd1);
    bus.m_ready = 1'b1;
    tick(4);
    check_val("hold_drain_valid", bus.m_valid, 1'b0);
    exp_l.push_back(l1); exp_r.push_back(r1);
    check_pairs("hold", base);

    // Reset during right-channel bit 12, word select high.
    base = obs_l.size(); vc0 = n_vcyc;
    l1 = DW'($urandom); r1 = DW'($urandom);
    send_chan(1'b0, l1, DW, 32, 1'b0);
    sbit(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) sbit(1'b1, r1[DW-1-i]);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 13; i < 32; i++) sbit(1'b1, 1'($urandom_range(0, 1)));
    tick(5);
    check_val("rst_mid_vcycles", 64'(n_vcyc - vc0), 64'd0);
    check_val("rst_mid_valid", bus.m_valid, 1'b0);
    l2 = DW'($urandom); r2 = DW'($urandom);
    send_frame(l2, r2);
    tick(10);
    exp_l.push_back(l2); exp_r.push_back(r2);
    check_pairs("rst_mid", base);

    // Left channel cut short after 10 bits, then a normal frame.
    base = obs_l.size(); fe0 = n_ferr;
    l1 = DW'($urandom); r1 = DW'($urandom);
    l2 = DW'($urandom); r2 = DW'($urandom);
    send_chan(1'b0, l1, 10, 11, 1'b0);
    send_chan(1'b1, r1, DW, 32, 1'b0);
    send_frame(l2, r2);
    tick(10);
`ifdef I2S_RX_FRAME_ERR_EN
    check_val("short_frame_err", 64'(n_ferr - fe0), 64'd1);
`else
    check_val("short_frame_err", 64'(n_ferr - fe0), 64'd0);
    mask = ~((DW'(1) << (DW - 10)) - DW'(1));
    exp_l.push_back(l1 & mask); exp_r.push_back(r1);
`endif
    exp_l.push_back(l2); exp_r.push_back(r2);
    check_pairs("short", base);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
